// File: rtl/neighbor_id_unpacker.sv
// Neighbor-ID unpacker: buffers packed neighbor-info words in a small FIFO,
// raises an early almost-full flag toward the neighbor-info controller, and
// serialises each word into single neighbor IDs with a valid/ready handshake.
module neighbor_id_unpacker #(
    parameter int ID_W         = 10,
    parameter int IDS_PER_WORD = 4,
    parameter int DEPTH        = 8,
    parameter int AF_MARGIN    = 2,
    localparam int CNT_W       = $clog2(IDS_PER_WORD + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [IDS_PER_WORD*ID_W-1:0] in_ids,
    input  logic [CNT_W-1:0]             in_cnt,
    input  logic [ID_W-1:0]              in_node_id,
    input  logic                         in_last,
    output logic                         full,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_W-1:0]              out_id,
    output logic [ID_W-1:0]              out_node_id,
    output logic                         out_last,
    output logic                         overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W   = (IDS_PER_WORD > 1) ? $clog2(IDS_PER_WORD) : 1;

    typedef enum logic {
        EMPTY,
        EMIT
    } state_t;

    // Word storage; contents need no reset because count/pointers gate every read.
    logic [IDS_PER_WORD*ID_W-1:0] idsMem  [DEPTH];
    logic [CNT_W-1:0]             cntMem  [DEPTH];
    logic [ID_W-1:0]              nodeMem [DEPTH];
    logic                         lastMem [DEPTH];

    state_t             state_q,    state_d;
    logic [PTR_W-1:0]   wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q,    rdPtr_d;
    logic [COUNT_W-1:0] count_q,    count_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic               full_q,     full_d;
    logic               overflow_q, overflow_d;

    logic [CNT_W-1:0]             clampedCnt;
    logic [IDS_PER_WORD*ID_W-1:0] headIds;
    logic [CNT_W-1:0]             headCnt;
    logic [ID_W-1:0]              headNode;
    logic                         headLast;
    logic                         atLastId;
    logic                         outValid;
    logic                         handshake;
    logic                         pop;
    logic                         wantPush;
    logic                         push;

    // Head decode, handshake/push/pop decisions and all next-state values.
    always_comb begin
        clampedCnt = (in_cnt > CNT_W'(IDS_PER_WORD)) ? CNT_W'(IDS_PER_WORD) : in_cnt;
        headIds    = idsMem[rdPtr_q];
        headCnt    = cntMem[rdPtr_q];
        headNode   = nodeMem[rdPtr_q];
        headLast   = lastMem[rdPtr_q];
        atLastId   = (CNT_W'(idx_q) == (headCnt - CNT_W'(1)));
        outValid   = (state_q == EMIT);
        handshake  = outValid && out_ready;
        pop        = handshake && atLastId;
        wantPush   = in_valid && (in_cnt != '0);
        push       = wantPush && ((count_q != COUNT_W'(DEPTH)) || pop);

        wrPtr_d    = push ? (wrPtr_q + PTR_W'(1)) : wrPtr_q;
        rdPtr_d    = pop  ? (rdPtr_q + PTR_W'(1)) : rdPtr_q;

        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - COUNT_W'(1);
        end

        idx_d = idx_q;
        if (pop) begin
            idx_d = '0;
        end else if (handshake) begin
            idx_d = idx_q + IDX_W'(1);
        end

        state_d    = (count_d != '0) ? EMIT : EMPTY;
        full_d     = (count_d >= COUNT_W'(DEPTH - AF_MARGIN));
        overflow_d = overflow_q || (wantPush && !push);
    end

    // Control state: pointers, occupancy, unpack index, FSM and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Accepted words are written at the write pointer with their clamped count.
    always_ff @(posedge clk) begin
        if (push) begin
            idsMem[wrPtr_q]  <= in_ids;
            cntMem[wrPtr_q]  <= clampedCnt;
            nodeMem[wrPtr_q] <= in_node_id;
            lastMem[wrPtr_q] <= in_last;
        end
    end

    // Show-ahead outputs taken straight from the head entry; zero while empty.
    always_comb begin
        out_valid   = outValid;
        out_id      = outValid ? headIds[idx_q*ID_W +: ID_W] : '0;
        out_node_id = outValid ? headNode : '0;
        out_last    = outValid && headLast && atLastId;
        full        = full_q;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_neighbor_id_unpacker.sv
// Self-checking bench for neighbor_id_unpacker: a word table plus hand-built
// sequences feed a scoreboard of expected IDs that is compared at every handshake.
module tb_neighbor_id_unpacker;

   localparam int ID_W      = 10;
   localparam int NIDS      = 4;
   localparam int DEPTH     = 8;
   localparam int AF_MARGIN = 2;

   typedef struct {
      logic [NIDS*ID_W-1:0] ids;
      logic [2:0]           cnt;
      logic [ID_W-1:0]      node;
      logic                 last;
      int                   expEmit;
   } vec_t;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [ID_W-1:0] node;
      logic            last;
      logic            eow;
   } exp_t;

   logic                 clk;
   logic                 reset;
   logic                 inValid;
   logic [NIDS*ID_W-1:0] inIds;
   logic [2:0]           inCnt;
   logic [ID_W-1:0]      inNodeId;
   logic                 inLast;
   logic                 full;
   logic                 outValid;
   logic                 outReady;
   logic [ID_W-1:0]      outId;
   logic [ID_W-1:0]      outNodeId;
   logic                 outLast;
   logic                 overflow;

   exp_t sbQ[$];
   int   modelCount;
   logic modelFull;
   logic modelOverflow;
   int   vectors;
   int   miscompares;
   vec_t vecs[6];

   neighbor_id_unpacker #(
      .ID_W(ID_W), .IDS_PER_WORD(NIDS), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ids(inIds), .in_cnt(inCnt),
      .in_node_id(inNodeId), .in_last(inLast), .full(full), .out_valid(outValid),
      .out_ready(outReady), .out_id(outId), .out_node_id(outNodeId),
      .out_last(outLast), .overflow(overflow)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time bound so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [NIDS*ID_W-1:0] packIds(input int a, input int b, input int c, input int d);
      logic [ID_W-1:0] sa, sb, sc, sd;
      sa = ID_W'(a); sb = ID_W'(b); sc = ID_W'(c); sd = ID_W'(d);
      return {sd, sc, sb, sa};
   endfunction

   task automatic compare(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare visible outputs against the scoreboard head and the flag model.
   task automatic checkOutput();
      compare("out_valid", int'(outValid), int'(sbQ.size() != 0));
      if (sbQ.size() != 0) begin
         compare("out_id",      int'(outId),     int'(sbQ[0].id));
         compare("out_node_id", int'(outNodeId), int'(sbQ[0].node));
         compare("out_last",    int'(outLast),   int'(sbQ[0].last));
      end else begin
         compare("out_last_idle", int'(outLast), 0);
      end
      compare("full",     int'(full),     int'(modelFull));
      compare("overflow", int'(overflow), int'(modelOverflow));
   endtask

   // One clock cycle: check outputs, drive inputs, update the model for the coming edge.
   task automatic applyStimulus(input logic v, input vec_t w, input logic ready);
      logic handshake, pop, wantPush, push;
      @(negedge clk);
      checkOutput();
      inValid  = v;
      inIds    = w.ids;
      inCnt    = w.cnt;
      inNodeId = w.node;
      inLast   = w.last;
      outReady = ready;
      handshake = (sbQ.size() != 0) && ready;
      pop       = handshake && sbQ[0].eow;
      wantPush  = v && (w.expEmit != 0);
      push      = wantPush && ((modelCount < DEPTH) || pop);
      if (wantPush && !push) modelOverflow = 1'b1;
      if (handshake) void'(sbQ.pop_front());
      if (pop) modelCount--;
      if (push) begin
         modelCount++;
         for (int k = 0; k < w.expEmit; k++) begin
            exp_t e;
            e.id   = w.ids[k*ID_W +: ID_W];
            e.node = w.node;
            e.eow  = (k == w.expEmit - 1);
            e.last = w.last && e.eow;
            sbQ.push_back(e);
         end
      end
      modelFull = (modelCount >= DEPTH - AF_MARGIN);
   endtask

   function automatic vec_t mkWord(input logic [NIDS*ID_W-1:0] ids, input int cnt, input int node,
                                   input logic last, input int expEmit);
      vec_t w;
      w.ids = ids; w.cnt = 3'(cnt); w.node = ID_W'(node); w.last = last; w.expEmit = expEmit;
      return w;
   endfunction

   task automatic idle(input logic ready);
      applyStimulus(1'b0, mkWord('0, 0, 0, 1'b0, 0), ready);
   endtask

   // Drain everything with out_ready high, bounded; then confirm valid drops.
   task automatic drain();
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < 200) begin
         idle(1'b1);
         n++;
      end
      compare("drain_done", int'(sbQ.size()), 0);
      idle(1'b1);
   endtask

   task automatic clearModel();
      sbQ.delete();
      modelCount    = 0;
      modelFull     = 1'b0;
      modelOverflow = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clearModel();
      reset    = 1'b0;
      inValid  = 1'b0;
      inIds    = '0;
      inCnt    = '0;
      inNodeId = '0;
      inLast   = 1'b0;
      outReady = 1'b0;

      vecs[0] = mkWord(packIds(10, 20, 30, 40),     3, 5,  1'b1, 3);
      vecs[1] = mkWord(packIds(1, 2, 3, 4),         0, 6,  1'b1, 0);
      vecs[2] = mkWord(packIds(100, 200, 300, 400), 7, 7,  1'b0, 4);
      vecs[3] = mkWord(packIds(11, 12, 13, 14),     4, 9,  1'b0, 4);
      vecs[4] = mkWord(packIds(15, 16, 17, 18),     4, 9,  1'b1, 4);
      vecs[5] = mkWord(packIds(1023, 0, 512, 7),    1, 3,  1'b1, 1);

      #12;
      compare("reset_valid",    int'(outValid),  0);
      compare("reset_full",     int'(full),      0);
      compare("reset_overflow", int'(overflow),  0);
      compare("reset_out_id",   int'(outId),     0);
      compare("reset_node_id",  int'(outNodeId), 0);
      compare("reset_last",     int'(outLast),   0);
      reset = 1'b1;

      // Single word, then the table words one by one with out_ready high.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, vecs[i], 1'b1);
         drain();
      end

      // Back-to-back table words: no bubble between words.
      for (int i = 2; i < 5; i++) applyStimulus(1'b1, vecs[i], 1'b1);
      drain();

      // Stall mid-word for five cycles, then resume at the same index.
      applyStimulus(1'b1, mkWord(packIds(51, 52, 53, 54), 4, 8, 1'b1, 4), 1'b1);
      idle(1'b1);
      for (int i = 0; i < 5; i++) idle(1'b0);
      drain();

      // Fill to DEPTH, then push while the head's last ID handshakes.
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, mkWord(packIds(60 + i, 0, 0, 0), 1, i, 1'b1, 1), 1'b0);
      applyStimulus(1'b1, mkWord(packIds(99, 98, 0, 0), 2, 12, 1'b1, 2), 1'b1);
      idle(1'b0);
      drain();

      // Back-pressure: six words raise full, two more fit, the ninth overflows.
      for (int i = 0; i < DEPTH + 1; i++)
         applyStimulus(1'b1, mkWord(packIds(200 + i, 300 + i, 0, 0), 2, 20 + i, 1'b0, 2), 1'b0);
      idle(1'b0);
      drain();

      // Reset mid-stream with three words queued and the head at index 2.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, mkWord(packIds(70 + i, 80 + i, 90 + i, 95 + i), 4, 30 + i, 1'b1, 4), 1'b0);
      idle(1'b1);
      idle(1'b1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      compare("async_reset_valid",    int'(outValid), 0);
      compare("async_reset_full",     int'(full),     0);
      compare("async_reset_overflow", int'(overflow), 0);
      clearModel();
      @(negedge clk);
      #3;
      reset = 1'b1;
      applyStimulus(1'b1, mkWord(packIds(400, 401, 402, 403), 4, 40, 1'b1, 4), 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
